cascade_cmp_seq: RTL
====================

Name: cascade_cmp_seq

Overview:
- Sequential controller that compares two wide operands by running a 4-bit cascadable magnitude-compare step once per clock, LSB nibble first.
- Each step folds one nibble pair into a running {gt, lt, eq} cascade state, using the team's 4-bit comparator cascade rule.
- Used wherever operands wider than 4 bits need a compare without instantiating a full-width comparator.
- start/busy/done handshake toward the requesting block.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  operand A; captured on the accepted start.
- b  input  W  operand B; captured on the accepted start.
- cas_in  input  3  initial cascade state {gt_in, lt_in, eq_in}; captured on the accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse when the result updates.
- eq  output  1  registered result: A equal.
- lt  output  1  registered result: A less than B.
- gt  output  1  registered result: A greater than B.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, eq=0, lt=0, gt=0; internal registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, capture a, b and cas_in into shift/cascade registers, clear the nibble counter cnt, and go to RUN.
- RUN: one nibble pair is processed per edge, slice cnt (bits 4*cnt+3 : 4*cnt), LSB-first. Cascade update for nibbles x, y with state (g, l, e):
  - e' = (x==y) & e
  - l' = (x<y) | ((x==y) & l)
  - g' = (x>y) | ((x==y) & g)
- After processing slice NIBBLES-1, go to DONE and load eq/lt/gt from the final cascade state.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: done is high exactly NIBBLES+1 cycles after the cycle in which start was accepted.
- eq/lt/gt hold the previous result through RUN and until the next DONE. They do not change at any other time.
- start while busy=1 (including the DONE cycle) is ignored and not queued. start in the cycle after done is accepted.
- a, b and cas_in may change freely after capture with no effect.
- Cascade corner cases follow the datapath exactly:
  - cas_in=000 with A==B gives eq=lt=gt=0.
  - Multiple cas_in bits set with A==B pass through unchanged.
- cnt counts 0..NIBBLES-1. It never wraps inside one operation and is reset on each accept.
- rst in any state, including mid-RUN: immediate return to IDLE, outputs cleared, no done pulse.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are two's complement. On the MSB slice, if a[W-1] != b[W-1], the final state is forced to lt=a[W-1], gt=b[W-1], eq=0, ignoring the cascade. Otherwise the normal update applies.
- Undefined: unsigned compare only, and no sign logic is synthesized.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h1234, cas_in=001, start for 1 cycle -> busy for 5 cycles; done at cycle 5 after start; eq=1, lt=0, gt=0.
- a=16'h1235, b=16'h1234 -> gt=1. Then a=16'h0FFF, b=16'h1000 -> lt=1 (MSB overrides lower nibbles).
- a=b=16'hABCD with cas_in=000 -> eq=lt=gt=0. Same operands with cas_in=010 -> lt=1 only.
- a=16'h8000, b=16'h7FFF -> gt=1 without CMP_SIGNED_EN; lt=1 with CMP_SIGNED_EN.
- start held high continuously -> accepted only from IDLE. Exactly one done per NIBBLES+2 cycles. Operands changed mid-RUN do not affect the result.
- rst asserted during the second RUN cycle -> next cycle busy=0, eq=lt=gt=0; done never pulses. A new start afterwards completes normally.

Source files
------------

// File: rtl/cascade_cmp_seq_if.sv
// rtl/cascade_cmp_seq_if.sv - request/result bundle for the sequential cascade comparator
//
// Purpose: groups the start/busy/done handshake, the operands and the
//          compare results into one port.
// Signals:
//   start   requester -> comparator, request (sampled only while busy=0)
//   a, b    requester -> comparator, W = 4*NIBBLES operands
//   cas_in  requester -> comparator, initial cascade state {gt, lt, eq}
//   busy    comparator -> requester, high while the operation runs and in its done cycle
//   done    comparator -> requester, one-cycle pulse when eq/lt/gt update
//   eq/lt/gt comparator -> requester, registered result
// Modports: master = requester side, slave = comparator side.
interface cascade_cmp_seq_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic [2:0]             cas_in;
  logic                   busy;
  logic                   done;
  logic                   eq;
  logic                   lt;
  logic                   gt;

  modport master (
    output start, a, b, cas_in,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, a, b, cas_in,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/cascade_cmp_seq.sv
// rtl/cascade_cmp_seq.sv - multi-cycle magnitude compare, one 4-bit cascade step per clock
//
// Purpose: compares two 4*NIBBLES-bit operands LSB nibble first, folding each
//          nibble pair into a running {gt, lt, eq} cascade state. The result is
//          registered and presented with a one-cycle done pulse NIBBLES+1
//          cycles after the start is accepted.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   cascade_cmp_seq_if.slave (start, a, b, cas_in in; busy, done, eq, lt, gt out)
// Build option: define CMP_SIGNED_EN for two's complement operands (the MSB
//               slice forces the result when the sign bits differ).
module cascade_cmp_seq #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  cascade_cmp_seq_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      cas_q, cas_d;   // {g, l, e}
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      res_q, res_d;   // {gt, lt, eq}

  logic [3:0]      x, y;
  logic            last;
  logic [2:0]      step;

  // Operands shift right each step, so the current slice is always the low nibble.
  assign x    = a_q[3:0];
  assign y    = b_q[3:0];
  assign last = (cnt_q == CW'(NIBBLES - 1));

  always_comb begin
    step[0] = (x == y) & cas_q[0];
    step[1] = (x < y) | ((x == y) & cas_q[1]);
    step[2] = (x > y) | ((x == y) & cas_q[2]);
`ifdef CMP_SIGNED_EN
    // On the sign slice differing sign bits decide the result outright.
    if (last && (x[3] != y[3])) begin
      step = {y[3], x[3], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cas_q   <= cas_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cas_d   = cas_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cas_d   = bus.cas_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cas_d = step;
        if (last) begin
          res_d   = step;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.gt   = res_q[2];
  assign bus.lt   = res_q[1];
  assign bus.eq   = res_q[0];
endmodule
